button_event_arbiter: RTL and testbench

Multi-channel button front end. It shares one sample-tick prescaler across N_CH debounce channels, derives press, release and long-press events per channel, and serialises them through a round-robin arbiter onto a single valid/ready event stream. It sits between raw board pushbuttons and the control FSMs, and replaces per-button debouncer instances wherever events rather than levels are consumed.

---
 rtl/button_event_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_button_event_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// -----------------------------------------------------------------------------
// button_event_arbiter
//
// Multi-channel pushbutton front end. One shared prescaler produces a sample
// tick. Each channel synchronises its raw input and debounces it with a
// stability counter. It then derives press, release and long-press events.
// Every channel has a one-deep pending slot. A round-robin arbiter serialises
// the slots onto a single valid/ready event stream.
//
// Ports
//   clk        system clock
//   rst_a_p    synchronous, active-high reset
//   btn_in     raw asynchronous button inputs, active-high (N_CH)
//   btn_level  debounced button levels (N_CH)
//   evt_valid  event output holds a valid event
//   evt_ready  consumer accepts the event when evt_valid & evt_ready
//   evt_ch     channel index of the presented event
//   evt_type   01 press, 10 release, 11 long-press
//   overflow   one-cycle pulse when at least one event was dropped
// -----------------------------------------------------------------------------
module button_event_arbiter #(
    parameter int N_CH         = 4,
    parameter int TICK_MAX     = 50000,
    parameter int STABLE_TICKS = 4,
    parameter int LONG_TICKS   = 200
) (
    input  logic                    clk,
    input  logic                    rst_a_p,
    input  logic [N_CH-1:0]         btn_in,
    output logic [N_CH-1:0]         btn_level,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(N_CH)-1:0] evt_ch,
    output logic [1:0]              evt_type,
    output logic                    overflow
);

    localparam int CH_W  = $clog2(N_CH);
    localparam int TCK_W = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int STB_W = $clog2(STABLE_TICKS + 1);
    localparam int LNG_W = $clog2(LONG_TICKS + 1);

    localparam logic [TCK_W-1:0] TCK_LAST = TCK_W'(TICK_MAX - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_TICKS - 1);
    localparam logic [LNG_W-1:0] LNG_MAX  = LNG_W'(LONG_TICKS);
    localparam logic [LNG_W-1:0] LNG_LAST = LNG_W'(LONG_TICKS - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
    localparam logic [CH_W:0]    N_CH_L   = (CH_W + 1)'(N_CH);

    localparam logic [1:0] EVT_NONE    = 2'b00;
    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_RELEASE = 2'b10;
    localparam logic [1:0] EVT_LONG    = 2'b11;

    // Registers
    logic [TCK_W-1:0] r_tick_cnt;
    logic [N_CH-1:0]  r_sync_p0;
    logic [N_CH-1:0]  r_sync_p1;
    logic [N_CH-1:0]  r_level;
    logic [STB_W-1:0] r_stab [N_CH];
    logic [LNG_W-1:0] r_hold [N_CH];
    logic [1:0]       r_pend [N_CH];
    logic [CH_W-1:0]  r_ptr;
    logic             r_evt_valid;
    logic [CH_W-1:0]  r_evt_ch;
    logic [1:0]       r_evt_type;
    logic             r_overflow;

    // Combinational next-state
    logic             w_tick;
    logic [N_CH-1:0]  w_level_nxt;
    logic [STB_W-1:0] w_stab_nxt [N_CH];
    logic [LNG_W-1:0] w_hold_nxt [N_CH];
    logic [N_CH-1:0]  w_raise;
    logic [1:0]       w_raise_type [N_CH];
    logic [N_CH-1:0]  w_pend_vld;
    logic [1:0]       w_pend_nxt [N_CH];
    logic [N_CH-1:0]  w_drop;
    logic             w_free;
    logic             w_grant_vld;
    logic [CH_W-1:0]  w_grant_ch;
    logic [CH_W:0]    w_idx;

    assign w_tick = (r_tick_cnt == TCK_LAST);
    assign w_free = !r_evt_valid || evt_ready;

    // ---- stage 0: tick-qualified debounce and event detection --------------
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_level_nxt[i]  = r_level[i];
            w_stab_nxt[i]   = r_stab[i];
            w_hold_nxt[i]   = r_hold[i];
            w_raise[i]      = 1'b0;
            w_raise_type[i] = EVT_NONE;
            if (w_tick) begin
                if (r_sync_p1[i] != r_level[i]) begin
                    if (r_stab[i] == STB_LAST) begin
                        w_level_nxt[i]  = ~r_level[i];
                        w_stab_nxt[i]   = '0;
                        w_raise[i]      = 1'b1;
                        w_raise_type[i] = r_level[i] ? EVT_RELEASE : EVT_PRESS;
                    end else begin
                        w_stab_nxt[i] = r_stab[i] + 1'b1;
                    end
                end else begin
                    w_stab_nxt[i] = '0;
                end
                // A toggle tick never advances the hold count, so a release
                // and a long-press cannot be raised together.
                if (!r_level[i] || (w_level_nxt[i] != r_level[i])) begin
                    w_hold_nxt[i] = '0;
                end else if (r_hold[i] != LNG_MAX) begin
                    w_hold_nxt[i] = r_hold[i] + 1'b1;
                    if (r_hold[i] == LNG_LAST) begin
                        w_raise[i]      = 1'b1;
                        w_raise_type[i] = EVT_LONG;
                    end
                end
            end
        end
    end

    // ---- stage 1: round-robin grant over pending slots ---------------------
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_ch  = '0;
        w_idx       = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_pend_vld[i] = (r_pend[i] != EVT_NONE);
        end
        for (int k = 0; k < N_CH; k++) begin
            w_idx = {1'b0, r_ptr} + (CH_W + 1)'(k);
            if (w_idx >= N_CH_L) begin
                w_idx = w_idx - N_CH_L;
            end
            if (w_free && !w_grant_vld && w_pend_vld[w_idx[CH_W-1:0]]) begin
                w_grant_vld = 1'b1;
                w_grant_ch  = w_idx[CH_W-1:0];
            end
        end
    end

    // A slot being granted this cycle counts as empty for a new event.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_drop[i]     = 1'b0;
            w_pend_nxt[i] = r_pend[i];
            if (w_grant_vld && (w_grant_ch == CH_W'(i))) begin
                w_pend_nxt[i] = EVT_NONE;
            end
            if (w_raise[i]) begin
                if ((r_pend[i] == EVT_NONE) ||
                    (w_grant_vld && (w_grant_ch == CH_W'(i)))) begin
                    w_pend_nxt[i] = w_raise_type[i];
                end else begin
                    w_drop[i] = 1'b1;
                end
            end
        end
    end

    // ---- stage 2: register update ------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            r_tick_cnt  <= '0;
            r_sync_p0   <= '0;
            r_sync_p1   <= '0;
            r_level     <= '0;
            r_ptr       <= '0;
            r_evt_valid <= 1'b0;
            r_evt_ch    <= '0;
            r_evt_type  <= EVT_NONE;
            r_overflow  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                r_stab[i] <= '0;
                r_hold[i] <= '0;
                r_pend[i] <= EVT_NONE;
            end
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_sync_p0  <= btn_in;
            r_sync_p1  <= r_sync_p0;
            r_level    <= w_level_nxt;
            r_overflow <= |w_drop;
            for (int i = 0; i < N_CH; i++) begin
                r_stab[i] <= w_stab_nxt[i];
                r_hold[i] <= w_hold_nxt[i];
                r_pend[i] <= w_pend_nxt[i];
            end
            if (w_free) begin
                r_evt_valid <= w_grant_vld;
                if (w_grant_vld) begin
                    r_evt_ch   <= w_grant_ch;
                    r_evt_type <= r_pend[w_grant_ch];
                    r_ptr      <= (w_grant_ch == CH_LAST) ? '0 : w_grant_ch + 1'b1;
                end
            end
        end
    end

    assign btn_level = r_level;
    assign evt_valid = r_evt_valid;
    assign evt_ch    = r_evt_ch;
    assign evt_type  = r_evt_type;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_button_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_button_event_arbiter
//
// Directed bench for button_event_arbiter with N_CH=4, TICK_MAX=4,
// STABLE_TICKS=3, LONG_TICKS=5. Stimulus pushes hand-derived expected events
// ({ch, type}) into a queue; a monitor pops and compares on each handshake.
// -----------------------------------------------------------------------------
module tb_button_event_arbiter;

    localparam int N_CH         = 4;
    localparam int TICK_MAX     = 4;
    localparam int STABLE_TICKS = 3;
    localparam int LONG_TICKS   = 5;

    logic            clk = 1'b0;
    logic            rst_a_p = 1'b1;
    logic [N_CH-1:0] btn_in = '0;
    logic [N_CH-1:0] btn_level;
    logic            evt_valid;
    logic            evt_ready = 1'b0;
    logic [1:0]      evt_ch;
    logic [1:0]      evt_type;
    logic            overflow;

    always #5 clk = ~clk;

    button_event_arbiter #(
        .N_CH         (N_CH),
        .TICK_MAX     (TICK_MAX),
        .STABLE_TICKS (STABLE_TICKS),
        .LONG_TICKS   (LONG_TICKS)
    ) dut (
        .clk       (clk),
        .rst_a_p   (rst_a_p),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_type  (evt_type),
        .overflow  (overflow)
    );

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];
    int         cyc = 0;
    int         hs_last = -10;
    int         hs_prev = -10;
    int         ov_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard compare on every accepted event.
    always @(negedge clk) begin
        cyc++;
        if (!rst_a_p) begin
            if (overflow) ov_cnt++;
            if (evt_valid && evt_ready) begin
                hs_prev = hs_last;
                hs_last = cyc;
                check("sb_has_expect", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("evt_ch_type", {28'd0, evt_ch, evt_type}, {28'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_level(input int ch, input logic val, input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((btn_level[ch] !== val) && (n < bound));
        check($sformatf("level_ch%0d", ch), btn_level[ch], val);
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < bound)) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        drive_edge();
        rst_a_p = 1'b1;
        drive_edge();
        rst_a_p = 1'b0;
    endtask

    // Measure cycles from btn_level rise until the long-press event shows.
    task automatic long_press_ch0(input string name);
        int n;
        int k;
        drive_edge();
        btn_in[0] = 1'b1;
        exp_q.push_back({2'd0, 2'b01});
        exp_q.push_back({2'd0, 2'b11});
        wait_level(0, 1'b1, 40, n);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(evt_valid && evt_type == 2'b11 && evt_ch == 2'd0) && (k < 40));
        check(name, k, 21);
        repeat (40) @(negedge clk);
        drive_edge();
        btn_in[0] = 1'b0;
        exp_q.push_back({2'd0, 2'b10});
        wait_drain(60);
        check({name, "_level_low"}, btn_level[0], 0);
    endtask

    initial begin
        int n;
        int bad;
        int ov_base;

        // ---- reset state
        repeat (3) @(negedge clk);
        check("rst_level", btn_level, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_ch", evt_ch, 0);
        check("rst_type", evt_type, 0);
        check("rst_overflow", overflow, 0);
        drive_edge();
        rst_a_p = 1'b0;

        // ---- 1: clean press on ch1, then release
        drive_edge();
        evt_ready = 1'b1;
        btn_in[1] = 1'b1;
        exp_q.push_back({2'd1, 2'b01});
        wait_level(1, 1'b1, 40, n);
        check("t1_latency_in_window", 32'((n >= 12) && (n <= 15)), 1);
        check("t1_valid_at_toggle", evt_valid, 0);
        @(negedge clk);
        check("t1_valid_next", evt_valid, 1);
        @(negedge clk);
        check("t1_valid_one_cycle", evt_valid, 0);
        drive_edge();
        btn_in[1] = 1'b0;
        exp_q.push_back({2'd1, 2'b10});
        wait_drain(60);

        // ---- 2: bounce on ch2 never accepted
        ov_base = ov_cnt;
        bad = 0;
        for (int p = 0; p < 7; p++) begin
            for (int c = 0; c < 12; c++) begin
                drive_edge();
                btn_in[2] = (c < 8);
                @(negedge clk);
                if (btn_level[2]) bad++;
            end
        end
        drive_edge();
        btn_in[2] = 1'b0;
        repeat (20) @(negedge clk);
        check("t2_level_glitches", bad, 0);
        check("t2_level_final", btn_level[2], 0);
        check("t2_overflow", ov_cnt - ov_base, 0);

        // ---- 3: arbitration order after a fresh reset (pointer 0)
        pulse_reset();
        drive_edge();
        btn_in[0] = 1'b1;
        btn_in[2] = 1'b1;
        exp_q.push_back({2'd0, 2'b01});
        exp_q.push_back({2'd2, 2'b01});
        wait_level(2, 1'b1, 40, n);
        check("t3_level0", btn_level[0], 1);
        wait_drain(20);
        check("t3_press_back_to_back", hs_last - hs_prev, 1);
        drive_edge();
        btn_in[0] = 1'b0;
        btn_in[2] = 1'b0;
        exp_q.push_back({2'd0, 2'b10});
        exp_q.push_back({2'd2, 2'b10});
        wait_drain(60);
        check("t3_rel02_back_to_back", hs_last - hs_prev, 1);
        drive_edge();
        btn_in[1] = 1'b1;
        btn_in[3] = 1'b1;
        exp_q.push_back({2'd3, 2'b01});
        exp_q.push_back({2'd1, 2'b01});
        wait_level(3, 1'b1, 40, n);
        wait_drain(20);
        drive_edge();
        btn_in[1] = 1'b0;
        btn_in[3] = 1'b0;
        exp_q.push_back({2'd3, 2'b10});
        exp_q.push_back({2'd1, 2'b10});
        wait_drain(60);
        check("t3_rel31_back_to_back", hs_last - hs_prev, 1);

        // ---- 4: backpressure, slot storage and a dropped event
        ov_base = ov_cnt;
        drive_edge();
        evt_ready = 1'b0;
        btn_in[3] = 1'b1;
        exp_q.push_back({2'd3, 2'b01});
        exp_q.push_back({2'd3, 2'b10});
        wait_level(3, 1'b1, 40, n);
        @(negedge clk);
        check("t4_held_valid", evt_valid, 1);
        check("t4_held_ch", evt_ch, 3);
        check("t4_held_type", evt_type, 1);
        drive_edge();
        btn_in[3] = 1'b0;
        bad = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!(evt_valid && evt_ch == 2'd3 && evt_type == 2'b01)) bad++;
        end while (btn_level[3] && (n < 40));
        check("t4_release_level", btn_level[3], 0);
        repeat (4) begin
            @(negedge clk);
            if (!(evt_valid && evt_ch == 2'd3 && evt_type == 2'b01)) bad++;
        end
        check("t4_output_stable", bad, 0);
        drive_edge();
        btn_in[3] = 1'b1;
        wait_level(3, 1'b1, 40, n);
        check("t4_overflow_pulse", overflow, 1);
        drive_edge();
        btn_in[3] = 1'b0;
        evt_ready = 1'b1;
        exp_q.push_back({2'd3, 2'b10});
        @(negedge clk);
        check("t4_overflow_one_cycle", overflow, 0);
        wait_drain(80);
        check("t4_overflow_count", ov_cnt - ov_base, 1);

        // ---- 5: long press twice (second shows the hold count was cleared)
        long_press_ch0("t5_long_latency_a");
        long_press_ch0("t5_long_latency_b");

        // ---- 6: reset while an event is presented and another is pending
        drive_edge();
        evt_ready = 1'b0;
        btn_in[1] = 1'b1;
        btn_in[2] = 1'b1;
        wait_level(2, 1'b1, 40, n);
        @(negedge clk);
        check("t6_valid_before_rst", evt_valid, 1);
        drive_edge();
        rst_a_p = 1'b1;
        btn_in = '0;
        drive_edge();
        rst_a_p = 1'b0;
        @(negedge clk);
        check("t6_level", btn_level, 0);
        check("t6_valid", evt_valid, 0);
        check("t6_ch", evt_ch, 0);
        check("t6_type", evt_type, 0);
        check("t6_overflow", overflow, 0);
        drive_edge();
        evt_ready = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (evt_valid) bad++;
        end
        check("t6_no_stale_event", bad, 0);

        check("sb_final_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
